// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath: UART transmitter datapath, downstream of the TX FSM.
// Latches the payload and parity settings on load, shifts data out LSB-first
// and drives the registered serial line.
// Ports:
//   clk           UART TX clock (one bit per cycle)
//   reset_n       asynchronous active-low reset
//   p_data_in     parallel payload, sampled on load
//   data_valid_in payload strobe shared with the FSM
//   par_en_in     parity enable, latched for status
//   par_typ_in    parity type, 0 even / 1 odd, latched on load
//   ser_en_in     FSM in DATA, advance the serializer
//   mux_sel_in    line select: 0 idle/stop, 1 start, 2 data, 3 parity
//   ser_done_out  last data bit is on its way this cycle (combinational)
//   tx_out        registered serial line
module uart_tx_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] p_data_in,
  input  logic                  data_valid_in,
  input  logic                  par_en_in,
  input  logic                  par_typ_in,
  input  logic                  ser_en_in,
  input  logic [1:0]            mux_sel_in,
  output logic                  ser_done_out,
  output logic                  tx_out
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;
  logic                  par_x_q;
  logic                  par_typ_q;
  logic                  par_en_q;
  logic                  par_q;
  logic                  load;
  logic                  tx_d;
  // Loads only while the FSM is in IDLE or STOP; valid elsewhere is ignored.
  assign load         = data_valid_in && (mux_sel_in == 2'd0);
  assign ser_done_out = ser_en_in && (bit_cnt == LAST);
  // Data reduction and type are held apart; their XOR is the parity bit.
  assign par_q        = par_x_q ^ par_typ_q;
  always_comb
    tx_d = (mux_sel_in == 2'd0) ? 1'b1 :
           (mux_sel_in == 2'd1) ? 1'b0 :
           (mux_sel_in == 2'd2) ? shreg[0] : par_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_out    <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_x_q   <= 1'b0;
      par_typ_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      tx_out  <= tx_d;
      bit_cnt <= (ser_en_in && !ser_done_out) ? bit_cnt + CW'(1) : '0;
      if (load) begin
        shreg     <= p_data_in;
        par_x_q   <= ^p_data_in;
        par_typ_q <= par_typ_in;
        par_en_q  <= par_en_in;
      end else if (ser_en_in) begin
        shreg <= shreg >> 1;
      end
    end
  // A parity phase is only legal for a frame loaded with parity enabled.
  a_par_sel: assert property (@(posedge clk) disable iff (!reset_n)
    (mux_sel_in == 2'd3) |-> par_en_q);
endmodule

// File: tb/tb_uart_tx_datapath.sv
// tb_uart_tx_datapath: random and directed frames against a frame-level line model.
module tb_uart_tx_datapath;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] p_data = '0;
  logic       dv = 1'b0, pe = 1'b0, pt = 1'b0, se = 1'b0;
  logic [1:0] sel = '0;
  logic       done, tx;
  logic       w_data = 1'b0, w_dv = 1'b0, w_pe = 1'b1, w_pt = 1'b0, w_se = 1'b0;
  logic [1:0] w_sel = '0;
  logic       w_done, w_tx;
  int         n_chk = 0, n_pass = 0;
  logic       prev_line = 1'b1;
  logic       w_prev = 1'b1;
  logic [1:0] w_sel_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       w_done_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       w_line_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  always #5 clk = ~clk;
  uart_tx_datapath #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .p_data_in(p_data), .data_valid_in(dv),
    .par_en_in(pe), .par_typ_in(pt), .ser_en_in(se), .mux_sel_in(sel),
    .ser_done_out(done), .tx_out(tx));
  uart_tx_datapath #(.DATA_WIDTH(1)) dut_w1 (
    .clk(clk), .reset_n(reset_n), .p_data_in(w_data), .data_valid_in(w_dv),
    .par_en_in(w_pe), .par_typ_in(w_pt), .ser_en_in(w_se), .mux_sel_in(w_sel),
    .ser_done_out(w_done), .tx_out(w_tx));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  // One FSM cycle: drive inputs, check the line from the previous cycle and
  // this cycle's ser_done, then remember what this cycle puts on the line.
  task automatic drive(input logic [1:0] s, input logic e, input logic v, input logic [7:0] d,
                       input logic t, input logic p, input logic exp_done, input logic exp_line);
    sel = s; se = e; dv = v; p_data = d; pt = t; pe = p;
    @(negedge clk);
    check("tx_out", tx, prev_line);
    check("ser_done", done, exp_done);
    prev_line = exp_line;
    @(posedge clk); #1;
  endtask
  task automatic load(input logic [7:0] d, input logic t, input logic p);
    drive(2'd0, 1'b0, 1'b1, d, t, p, 1'b0, 1'b1);
  endtask
  // Frame after its load: start, data LSB-first, optional parity, stop.
  // The stop cycle may carry the next load (back-to-back).
  task automatic frame(input logic [7:0] d, input logic t, input logic p, input bit inj,
                       input logic nv, input logic [7:0] nd, input logic nt, input logic np);
    drive(2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      drive(2'd2, 1'b1, inj && (i == 3), 8'h5A, ~t, 1'b1, i == 7, d[i]);
    if (p) drive(2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, (^d) ^ t);
    drive(2'd0, 1'b0, nv, nd, nt, np, 1'b0, 1'b1);
  endtask
  initial begin
    logic [7:0] r, cd, nd;
    logic ct, cp, nt, np, nv, inj;
    bit chained;
    r = 8'hC3;
    @(posedge clk); #1;
    check("rst_tx", tx, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_shreg", dut.shreg, 8'h00);
    check("rst_par", dut.par_q, 1'b0);
    check("rst_cnt", dut.bit_cnt, 3'd0);
    check("rst_w1_tx", w_tx, 1'b1);
    reset_n = 1'b1;
    load(8'hA5, 1'b0, 1'b1);
    frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    load(8'h03, 1'b1, 1'b1);
    frame(8'h03, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    load(8'h03, 1'b1, 1'b0);
    frame(8'h03, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    load(8'hFF, 1'b0, 1'b1);
    frame(8'hFF, 1'b0, 1'b1, 0, 1'b1, 8'h00, 1'b0, 1'b1);
    frame(8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    load(8'hA5, 1'b0, 1'b1);
    frame(8'hA5, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    load(r, 1'b0, 1'b1);
    drive(2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      drive(2'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, r[i]);
    sel = 2'd2; se = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_cnt", dut.bit_cnt, 3'd0);
    check("arst_shreg", dut.shreg, 8'h00);
    check("arst_par", dut.par_q, 1'b0);
    sel = 2'd0; se = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("arst_hold_tx", tx, 1'b1);
      @(posedge clk);
    end
    #1 reset_n = 1'b1;
    prev_line = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    load(8'h81, 1'b0, 1'b1);
    frame(8'h81, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    chained = 0;
    cd = 8'($urandom); ct = 1'($urandom); cp = 1'($urandom);
    for (int k = 0; k < 20; k++) begin
      nd = 8'($urandom); nt = 1'($urandom); np = 1'($urandom);
      nv = (k < 19) ? 1'($urandom) : 1'b0;
      inj = 1'($urandom);
      if (!chained) load(cd, ct, cp);
      frame(cd, ct, cp, inj, nv, nd, nt, np);
      if (!nv && $urandom_range(0, 1) == 1)
        drive(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chained = nv;
      cd = nd; ct = nt; cp = np;
    end
    w_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_sel = w_sel_seq[i]; w_se = (w_sel_seq[i] == 2'd2); w_dv = (i == 0);
      @(negedge clk);
      check("w1_tx", w_tx, w_prev);
      check("w1_done", w_done, w_done_seq[i]);
      w_prev = w_line_seq[i];
      @(posedge clk); #1;
    end
    w_dv = 1'b0;
    @(negedge clk);
    check("w1_tx_stop", w_tx, w_prev);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
